// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU.
// - opcode_e : 4-bit operation encoding; 0x0-0x7 match the legacy decode.
// - FLAG_*   : bit positions inside the registered flag vector.
// - state_e  : sequencer states (IDLE, MUL).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_HLT  = 4'h0,
        OP_SKZ  = 4'h1,
        OP_ADD  = 4'h2,
        OP_AND  = 4'h3,
        OP_XOR  = 4'h4,
        OP_LDA  = 4'h5,
        OP_STO  = 4'h6,
        OP_JMP  = 4'h7,
        OP_SUB  = 4'h8,
        OP_ADDC = 4'h9,
        OP_OR   = 4'hA,
        OP_SHL  = 4'hB,
        OP_SHR  = 4'hC,
        OP_ASR  = 4'hD,
        OP_MUL  = 4'hE,
        OP_NOT  = 4'hF
    } opcode_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_AZERO = 4;
    localparam int FLAG_W     = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, low WIDTH bits of a*b.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch a/b and begin (one cycle pulse)
//   a, b      : operands, sampled only on start
//   done      : high in the cycle whose edge performs the last iteration
//   product   : product value that edge produces (valid while done)
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] prod_nxt;

    always_comb begin
        prod_nxt = prod_q + (mp_q[0] ? mc_q : '0);
        done     = run_q && (cnt_q == CNT_LAST);
        // Final iteration result is handed out combinationally so the
        // parent can load it on the same edge.
        product  = prod_nxt;

        run_d  = run_q;
        cnt_d  = cnt_q;
        mc_d   = mc_q;
        mp_d   = mp_q;
        prod_d = prod_q;
        if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            mc_d   = a;
            mp_d   = b;
            prod_d = '0;
        end else if (run_q) begin
            mc_d   = {mc_q[WIDTH-2:0], 1'b0};
            mp_d   = {1'b0, mp_q[WIDTH-1:1]};
            prod_d = prod_nxt;
            cnt_d  = cnt_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            prod_q <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            mc_q   <= mc_d;
            mp_q   <= mp_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative multiply.
// State table:
//   ST_IDLE | accepting ops; single-cycle ops load the output register
//   ST_MUL  | multiply in progress, in_ready low, busy high
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : request handshake (in_a, in_b, opcode)
//   out_valid/out_ready            : result handshake
//   alu_out                        : registered result
//   a_is_zero, res_zero, carry,
//   overflow, negative             : registered flags
//   busy                           : multiply in progress
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             a_is_zero,
    output logic             res_zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             busy
);

    localparam int M = WIDTH - 1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    alu_out_q, alu_out_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                mul_az_q, mul_az_d;

    logic                accept, is_mul, mul_start, mul_done;
    logic [WIDTH-1:0]    mul_product;
    logic [WIDTH-1:0]    res, load_val;
    logic [WIDTH:0]      sum;
    logic                c_new, ovf_new, load, load_az;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        is_mul    = MUL_EN && (opcode == OP_MUL);
        mul_start = accept && is_mul;

        sum     = '0;
        res     = in_a;
        c_new   = flags_q[FLAG_CARRY];
        ovf_new = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD, OP_ADDC: begin
                sum = {1'b0, in_a} + {1'b0, in_b}
                    + ((opcode == OP_ADDC) ? (WIDTH+1)'(flags_q[FLAG_CARRY]) : '0);
                res     = sum[M:0];
                c_new   = sum[WIDTH];
                ovf_new = (in_a[M] == in_b[M]) && (sum[M] != in_a[M]);
            end
            OP_SUB: begin
                // carry = no borrow, from A + ~B + 1
                sum     = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
                res     = sum[M:0];
                c_new   = sum[WIDTH];
                ovf_new = (in_a[M] != in_b[M]) && (sum[M] != in_a[M]);
            end
            OP_AND: res = in_a & in_b;
            OP_XOR: res = in_a ^ in_b;
            OP_OR:  res = in_a | in_b;
            OP_LDA: res = in_b;
            OP_SHL: begin
                res   = {in_a[M-1:0], 1'b0};
                c_new = in_a[M];
            end
            OP_SHR: begin
                res   = {1'b0, in_a[M:1]};
                c_new = in_a[0];
            end
            OP_ASR: begin
                res   = {in_a[M], in_a[M:1]};
                c_new = in_a[0];
            end
            OP_NOT: res = ~in_a;
            default: res = in_a;
        endcase

        state_d   = state_q;
        busy_d    = busy_q;
        mul_az_d  = mul_az_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        load      = 1'b0;
        load_val  = res;
        load_az   = (in_a == '0);

        if (state_q == ST_IDLE) begin
            if (mul_start) begin
                state_d  = ST_MUL;
                busy_d   = 1'b1;
                mul_az_d = (in_a == '0);
            end else if (accept) begin
                load = 1'b1;
                flags_d[FLAG_CARRY] = c_new;
                flags_d[FLAG_OVF]   = ovf_new;
            end
        end else if (mul_done) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            load     = 1'b1;
            load_val = mul_product;
            load_az  = mul_az_q;
            flags_d[FLAG_OVF] = 1'b0;
        end

        if (load) begin
            alu_out_d           = load_val;
            flags_d[FLAG_ZERO]  = (load_val == '0);
            flags_d[FLAG_NEG]   = load_val[M];
            flags_d[FLAG_AZERO] = load_az;
        end
        // A held result clears on out_ready unless a new one replaces it.
        out_valid_d = load || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_out_q   <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_az_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mul_az_q    <= mul_az_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign a_is_zero = flags_q[FLAG_AZERO];
    assign res_zero  = flags_q[FLAG_ZERO];
    assign carry     = flags_q[FLAG_CARRY];
    assign overflow  = flags_q[FLAG_OVF];
    assign negative  = flags_q[FLAG_NEG];
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8, MUL_EN=1).
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic       a_is_zero, res_zero, carry, overflow, negative, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .a_is_zero (a_is_zero),
        .res_zero  (res_zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode   = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // result, carry, overflow, negative, res_zero after a single-cycle op
    task automatic chk_res(input string tag, input logic [7:0] r, input logic c,
                           input logic v, input logic n, input logic z);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"},   32'(alu_out),   32'(r));
        chk({tag, ".c"},     32'(carry),     32'(c));
        chk({tag, ".v"},     32'(overflow),  32'(v));
        chk({tag, ".n"},     32'(negative),  32'(n));
        chk({tag, ".z"},     32'(res_zero),  32'(z));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; opcode = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst.out",   32'(alu_out),   32'h0);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.busy",  32'(busy),      32'h0);
        chk("rst.c",     32'(carry),     32'h0);
        chk("rst.ready", 32'(in_ready),  32'h1);

        // signed overflow on ADD
        issue(OP_ADD, 8'h7F, 8'h01);
        chk_res("add7f", 8'h80, 1'b1 & 1'b0, 1'b1, 1'b1, 1'b0);

        // wrap to zero, then ADDC consumes the carry back-to-back
        issue(OP_ADD, 8'hFF, 8'h01);
        chk_res("addff", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_ADDC, 8'h00, 8'h00);
        chk_res("addc", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(OP_SUB, 8'h03, 8'h05);
        chk_res("sub35", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(OP_SUB, 8'h05, 8'h03);
        chk_res("sub53", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

        // multiply: 13*11 = 143, carry from the last SUB stays 1
        issue(OP_MUL, 8'h0D, 8'h0B);
        in_a = 8'hFF; in_b = 8'hFF; opcode = OP_ADD;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("mul.busy%0d", k),  32'(busy),      32'h1);
            chk($sformatf("mul.ready%0d", k), 32'(in_ready),  32'h0);
            chk($sformatf("mul.valid%0d", k), 32'(out_valid), 32'h0);
            step();
        end
        chk_res("mul", 8'h8F, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("mul.busy_end", 32'(busy), 32'h0);

        // reset mid-multiply discards it
        issue(OP_MUL, 8'h0D, 8'h0B);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst.out",   32'(alu_out),   32'h0);
        chk("mrst.valid", 32'(out_valid), 32'h0);
        chk("mrst.busy",  32'(busy),      32'h0);
        chk("mrst.c",     32'(carry),     32'h0);
        chk("mrst.ready", 32'(in_ready),  32'h1);
        for (int k = 0; k < 10; k++) step();
        chk("mrst.stray", 32'(out_valid), 32'h0);

        // back-pressure holds the result and blocks a new request
        out_ready = 1'b0;
        issue(OP_LDA, 8'h00, 8'h5A);
        chk("bp.out",   32'(alu_out),   32'h5A);
        chk("bp.az",    32'(a_is_zero), 32'h1);
        chk("bp.ready", 32'(in_ready),  32'h0);
        opcode = OP_ADD; in_a = 8'h01; in_b = 8'h02; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp.hold%0d", k),  32'(alu_out),   32'h5A);
            chk($sformatf("bp.valid%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("bp.rdy%0d", k),   32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.ready_rel", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk_res("bp.new", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp.az2", 32'(a_is_zero), 32'h0);

        issue(OP_SKZ, 8'h00, 8'hAA);
        chk("skz0.az",  32'(a_is_zero), 32'h1);
        chk("skz0.out", 32'(alu_out),   32'h00);
        issue(OP_SKZ, 8'h10, 8'hAA);
        chk("skz1.az",  32'(a_is_zero), 32'h0);
        chk("skz1.out", 32'(alu_out),   32'h10);

        issue(OP_SHL, 8'h81, 8'h00);
        chk_res("shl", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_AND, 8'hF0, 8'h3C);
        chk_res("and", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_ADDC, 8'h01, 8'h01);
        chk_res("addc2", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_SHR, 8'h81, 8'h00);
        chk_res("shr", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_ASR, 8'h81, 8'h00);
        chk_res("asr", 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_NOT, 8'h0F, 8'h00);
        chk_res("not", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_XOR, 8'hAA, 8'hFF);
        chk_res("xor", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_OR, 8'hF0, 8'h0C);
        chk_res("or", 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_JMP, 8'h33, 8'hCC);
        chk_res("jmp", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("drain.valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor to the CPU's 8-bit combinational ALU. Keeps opcodes 0-7 backward compatible with the existing instruction decode, using a 4-bit opcode whose MSB is 0 for those. Adds SUB, add-with-carry, OR, shifts, NOT and a multi-cycle multiply. Sits between the register/accumulator datapath and the controller, with valid/ready handshakes on both sides so the controller can stall on the multi-cycle multiply.

Parameters:
WIDTH, 8, data width in bits (>=4).
MUL_EN, 1, 1 enables the iterative multiplier; 0 makes opcode 0xE behave as pass-A.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
in_a  input  WIDTH  operand A (accumulator)
in_b  input  WIDTH  operand B (memory/data)
opcode  input  4  operation select
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  registered result
a_is_zero  output  1  registered (in_a == 0) of the accepted op (SKZ support)
res_zero  output  1  alu_out == 0
carry  output  1  sticky carry flag
overflow  output  1  signed overflow of last ADD/ADDC/SUB
negative  output  1  alu_out[WIDTH-1]
busy  output  1  multiply in progress

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - alu_out=0, all flags=0, out_valid=0, busy=0, FSM=IDLE.
  - Overrides everything, including an in-flight multiply, which is discarded.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Gives full-throughput back-to-back single-cycle ops.
- Output register:
  - Holds alu_out and flags stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads that same edge.
- Opcodes, with result truncated to WIDTH:
  - 0x0 HLT, 0x1 SKZ, 0x6 STO, 0x7 JMP: pass A.
  - 0x2 ADD: A+B. 0x3 AND: A&B. 0x4 XOR: A^B. 0x5 LDA: pass B.
  - 0x8 SUB: A-B. 0x9 ADDC: A+B+carry.
  - 0xA OR: A|B.
  - 0xB SHL: A<<1. 0xC SHR: A>>1. 0xD ASR: arithmetic A>>1.
  - 0xE MUL: low WIDTH bits of A*B, unsigned.
  - 0xF NOT: ~A.
- Flags:
  - carry updates on:
    - ADD/ADDC: carry-out.
    - SUB: carry-out of A+~B+1 (1 = no borrow).
    - SHL: old A[WIDTH-1].
    - SHR/ASR: old A[0].
  - carry is unchanged on all other ops.
  - overflow is set on signed overflow for ADD/ADDC/SUB; cleared on all other ops.
  - res_zero, negative and a_is_zero update on every completed op.
- Latency:
  - Single-cycle ops: result visible the cycle after accept (1 cycle).
- FSM states: IDLE, MUL.
  - IDLE -> MUL: on accept with opcode 0xE and MUL_EN=1. Latch A and B, clear the partial product, busy=1, counter=0.
  - MUL: shift-add one bit of B per cycle. After WIDTH iterations load the output register, set out_valid, busy=0, return to IDLE.
  - MUL latency is WIDTH+1 cycles from accept to out_valid.
  - in_ready=0 throughout MUL.
- MUL flags: carry unchanged, overflow=0.
- Boundary cases:
  - 0xFF+0x01 (WIDTH=8): result 0x00, carry=1, res_zero=1.
  - MUL result completing while a previous result is still held: cannot occur, because accept requires the output slot free or draining.
  - Input changes during MUL are ignored (operands latched at accept).

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum/localparams (OP_HLT ... OP_NOT);
  - the flag-vector field indices;
  - the FSM state encoding.
- One sub-module: alu_mul_iter (iterative shift-add multiplier with start/done). Parent owns the handshake and the flags.

Test Plan:
1. Reset, then ADD 0x7F+0x01 with out_ready=1 -> next cycle alu_out=0x80, overflow=1, negative=1, carry=0.
2. ADD 0xFF+0x01, then ADDC 0x00+0x00 back-to-back -> 0x00 (carry=1, res_zero=1), then 0x01 (carry=0).
3. SUB 0x03-0x05 -> 0xFE, carry=0, negative=1. SUB 0x05-0x03 -> 0x02, carry=1.
4. MUL 0x0D*0x0B (WIDTH=8) -> busy for 8 cycles, in_ready=0, out_valid on cycle 9 with 0x8F. rst asserted at cycle 4 of a repeat -> all outputs 0 next edge, in_ready=1.
5. Hold out_ready=0 after a LDA 0x5A -> alu_out stays 0x5A, in_ready=0, and a new request is not accepted. Release -> the new op completes one cycle later.
6. SKZ with in_a=0x00, then in_a=0x10 -> a_is_zero=1, then 0. SHL 0x81 -> 0x02, carry=1. ASR 0x81 -> 0xC0, carry=1.
